// File: rtl/wb_master_port.sv
//----------------------------------------------------------------------------
// wb_master_port : single-beat Wishbone initiator behind a valid/ready port
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module wb_master_port #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic                  req_we_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_wdata_o,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic [DATA_WIDTH-1:0] wb_rdata_i,
  input  logic                  wb_ack_i,
  output logic [7:0]            err_count_o
);

  localparam int C_CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_TMO_LAST =
    C_CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                r_state,      w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr,       w_addr_next;
  logic [DATA_WIDTH-1:0] r_wdata,      w_wdata_next;
  logic                  r_we,         w_we_next;
  logic                  r_stb,        w_stb_next;
  logic                  r_rsp_valid,  w_rsp_valid_next;
  logic [DATA_WIDTH-1:0] r_rsp_rdata,  w_rsp_rdata_next;
  logic                  r_rsp_err,    w_rsp_err_next;
  logic [7:0]            r_err_count,  w_err_count_next;
  logic [C_CNT_W-1:0]    r_tmo_cnt,    w_tmo_cnt_next;
  logic                  w_req_ready;
  logic                  w_timeout;

  assign w_req_ready = (r_state == ST_IDLE) && en_i;
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == C_TMO_LAST);

  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_wdata_next     = r_wdata;
    w_we_next        = r_we;
    w_stb_next       = r_stb;
    w_rsp_valid_next = 1'b0;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_err_next   = r_rsp_err;
    w_err_count_next = r_err_count;
    w_tmo_cnt_next   = r_tmo_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i && w_req_ready) begin
          w_state_next   = ST_BUS;
          w_addr_next    = req_addr_i;
          w_wdata_next   = req_wdata_i;
          w_we_next      = req_we_i;
          w_stb_next     = 1'b1;
          w_tmo_cnt_next = '0;
        end
      end
      ST_BUS: begin
        // An ack on the final timeout cycle still completes the transfer cleanly.
        if (wb_ack_i) begin
          w_state_next     = ST_RESP;
          w_stb_next       = 1'b0;
          w_we_next        = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = 1'b0;
          w_rsp_rdata_next = r_we ? '0 : wb_rdata_i;
        end else if (w_timeout) begin
          w_state_next     = ST_RESP;
          w_stb_next       = 1'b0;
          w_we_next        = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = 1'b1;
          w_rsp_rdata_next = '0;
          if (r_err_count != 8'hFF) begin
            w_err_count_next = r_err_count + 8'd1;
          end
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + C_CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_stb       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_err_count <= 8'd0;
      r_tmo_cnt   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
      r_we        <= w_we_next;
      r_stb       <= w_stb_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_err   <= w_rsp_err_next;
      r_err_count <= w_err_count_next;
      r_tmo_cnt   <= w_tmo_cnt_next;
    end
  end

  assign req_ready_o = w_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign wb_addr_o   = r_addr;
  assign wb_wdata_o  = r_wdata;
  assign wb_we_o     = r_we;
  assign wb_stb_o    = r_stb;
  assign wb_cyc_o    = r_stb;
  assign err_count_o = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_master_port.sv
//----------------------------------------------------------------------------
// tb_wb_master_port : directed bench with a transfer-level reference model
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_wb_master_port;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          wb_clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          req_we_i = 1'b0;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_wdata_o;
  logic          wb_we_o;
  logic          wb_stb_o;
  logic          wb_cyc_o;
  logic [DW-1:0] wb_rdata_i = '0;
  logic          wb_ack_i = 1'b0;
  logic [7:0]    err_count_o;

  wb_master_port #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .req_we_i   (req_we_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .wb_addr_o  (wb_addr_o),
    .wb_wdata_o (wb_wdata_o),
    .wb_we_o    (wb_we_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_rdata_i (wb_rdata_i),
    .wb_ack_i   (wb_ack_i),
    .err_count_o(err_count_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: acks in the ack_delay-th strobe cycle (0 = never); force_ack injects a stray ack.
  int            ack_delay = 1;
  int            stb_age = 0;
  int            acks = 0;
  bit            use_cnt = 1'b0;
  bit            force_ack = 1'b0;
  logic [DW-1:0] slave_rdata = '0;

  always @(posedge wb_clk_i) begin
    #1;
    if (wb_stb_o) stb_age++;
    else stb_age = 0;
    wb_ack_i = force_ack || (wb_stb_o && (ack_delay != 0) && (stb_age == ack_delay));
    if (wb_ack_i) begin
      acks++;
      wb_rdata_i = use_cnt ? (32'hC0DE_0000 + DW'(acks)) : slave_rdata;
    end else begin
      wb_rdata_i = 32'h0BAD_0BAD;
    end
  end

  // Reference model: one transfer at a time, described by how many strobe cycles have elapsed.
  bit            m_busy = 1'b0;
  bit            m_resp = 1'b0;
  int            m_stb_cycles = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_err = 1'b0;
  int            m_errcnt = 0;
  int            cyc_n = 0;
  int            acc_log[$];

  always @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy = 1'b0; m_resp = 1'b0; m_stb_cycles = 0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0; m_errcnt = 0;
    end else begin
      cyc_n++;
      if (m_busy) begin
        m_stb_cycles++;
        if (wb_ack_i) begin
          m_busy = 1'b0; m_resp = 1'b1; m_err = 1'b0;
          m_rdata = m_we ? '0 : wb_rdata_i;
        end else if (TMO != 0 && m_stb_cycles == TMO) begin
          m_busy = 1'b0; m_resp = 1'b1; m_err = 1'b1; m_rdata = '0;
          if (m_errcnt < 255) m_errcnt++;
        end
      end else if (m_resp) begin
        m_resp = 1'b0;
      end else if (en_i && req_valid_i) begin
        m_busy = 1'b1; m_stb_cycles = 0;
        m_addr = req_addr_i; m_wdata = req_wdata_i; m_we = req_we_i;
        acc_log.push_back(cyc_n);
      end
    end
  end

  // Compare process plus an observer recording what the bus actually did.
  int            stb_run = 0;
  int            last_stb = 0;
  int            rsp_cnt = 0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;
  logic          seen_we = 1'b0;
  logic [AW-1:0] seen_addr = '0;
  logic [DW-1:0] seen_wdata = '0;
  logic [DW-1:0] rsp_q[$];

  always @(negedge wb_clk_i) begin
    if (rst_ni) begin
      chk("req_ready",   req_ready_o, !m_busy && !m_resp && en_i);
      chk("wb_stb",      wb_stb_o,    m_busy);
      chk("wb_cyc",      wb_cyc_o,    m_busy);
      chk("wb_we",       wb_we_o,     m_busy && m_we);
      chk("wb_addr",     wb_addr_o,   m_addr);
      chk("wb_wdata",    wb_wdata_o,  m_wdata);
      chk("rsp_valid",   rsp_valid_o, m_resp);
      chk("rsp_rdata",   rsp_rdata_o, m_rdata);
      chk("rsp_err",     rsp_err_o,   m_err);
      chk("err_count",   err_count_o, 8'(m_errcnt));
      if (wb_stb_o) begin
        stb_run++;
        seen_we = wb_we_o; seen_addr = wb_addr_o; seen_wdata = wb_wdata_o;
      end
      if (rsp_valid_o) begin
        last_stb = stb_run; stb_run = 0; rsp_cnt++;
        last_rdata = rsp_rdata_o; last_err = rsp_err_o;
        rsp_q.push_back(rsp_rdata_o);
      end
    end
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #2;
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                        input int dly);
    logic r;
    int   n;
    n = 0;
    ack_delay = dly;
    req_addr_i = a; req_wdata_i = d; req_we_i = we; req_valid_i = 1'b1;
    do begin
      r = req_ready_o;
      tick();
      n++;
    end while (!r && n < 50);
    req_valid_i = 1'b0;
    req_addr_i = 32'hFFFF_FFFF; req_wdata_i = 32'hFFFF_FFFF; req_we_i = ~we;
    chk("accepted", r, 1'b1);
  endtask

  task automatic wait_rsp();
    int n;
    int start;
    n = 0;
    start = rsp_cnt;
    while (rsp_cnt == start && n < 100) begin
      tick();
      n++;
    end
    chk("rsp_seen", rsp_cnt != start, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int qbase;
    int n;
    int start;

    #12;
    chk("rst_stb",       wb_stb_o,    1'b0);
    chk("rst_cyc",       wb_cyc_o,    1'b0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_err_count", err_count_o, 8'd0);
    chk("rst_addr",      wb_addr_o,   32'h0);
    chk("rst_rdata",     rsp_rdata_o, 32'h0);
    tick();
    rst_ni = 1'b1;
    en_i = 1'b1;
    tick();

    // Read with ack in the second strobe cycle.
    slave_rdata = 32'hDEAD_BEEF;
    do_req(32'h0000_2004, 32'h0, 1'b0, 2);
    wait_rsp();
    chk("rd_stb_cycles", last_stb,   2);
    chk("rd_rdata",      last_rdata, 32'hDEAD_BEEF);
    chk("rd_err",        last_err,   1'b0);
    chk("rd_addr",       seen_addr,  32'h0000_2004);
    chk("rd_we",         seen_we,    1'b0);
    tick();

    // Write with immediate ack.
    do_req(32'h0000_1000, 32'h1234_5678, 1'b1, 1);
    wait_rsp();
    chk("wr_stb_cycles", last_stb,   1);
    chk("wr_we",         seen_we,    1'b1);
    chk("wr_wdata",      seen_wdata, 32'h1234_5678);
    chk("wr_rdata",      last_rdata, 32'h0);
    chk("wr_err",        last_err,   1'b0);
    tick();

    // Back-to-back reads with valid held high.
    base = acc_log.size();
    qbase = rsp_q.size();
    use_cnt = 1'b1; acks = 0; ack_delay = 1;
    req_addr_i = 32'h0000_0040; req_we_i = 1'b0; req_valid_i = 1'b1;
    n = 0;
    while (acc_log.size() < base + 3 && n < 50) begin
      tick();
      n++;
    end
    req_valid_i = 1'b0;
    repeat (5) tick();
    use_cnt = 1'b0;
    chk("b2b_accepts",   acc_log.size() - base, 3);
    chk("b2b_responses", rsp_q.size() - qbase,  3);
    if (acc_log.size() >= base + 3) begin
      chk("b2b_gap0", acc_log[base+1] - acc_log[base],   3);
      chk("b2b_gap1", acc_log[base+2] - acc_log[base+1], 3);
    end
    if (rsp_q.size() >= qbase + 3) begin
      chk("b2b_rsp0", rsp_q[qbase],   32'hC0DE_0001);
      chk("b2b_rsp1", rsp_q[qbase+1], 32'hC0DE_0002);
      chk("b2b_rsp2", rsp_q[qbase+2], 32'hC0DE_0003);
    end

    // Timeout with no ack, then a stray late ack.
    do_req(32'h0000_3000, 32'h0, 1'b0, 0);
    wait_rsp();
    chk("tmo_stb_cycles", last_stb,    16);
    chk("tmo_err",        last_err,    1'b1);
    chk("tmo_rdata",      last_rdata,  32'h0);
    chk("tmo_err_count",  err_count_o, 8'd1);
    start = rsp_cnt;
    tick(); tick();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    repeat (3) tick();
    chk("late_ack_rsp",   rsp_cnt - start, 0);
    chk("late_ack_count", err_count_o,     8'd1);

    // Ack on the last allowed strobe cycle wins over the timeout.
    slave_rdata = 32'hA5A5_5A5A;
    do_req(32'h0000_3004, 32'h0, 1'b0, 16);
    wait_rsp();
    chk("edge_stb_cycles", last_stb,    16);
    chk("edge_err",        last_err,    1'b0);
    chk("edge_rdata",      last_rdata,  32'hA5A5_5A5A);
    chk("edge_err_count",  err_count_o, 8'd1);
    tick();

    // Disabled while idle: nothing is accepted.
    en_i = 1'b0;
    req_valid_i = 1'b1;
    repeat (4) tick();
    chk("dis_ready", req_ready_o, 1'b0);
    chk("dis_stb",   wb_stb_o,    1'b0);
    req_valid_i = 1'b0;
    en_i = 1'b1;
    tick();

    // Enable dropped mid-transfer: the transfer still completes.
    slave_rdata = 32'h55AA_33CC;
    do_req(32'h0000_4000, 32'h0, 1'b0, 4);
    en_i = 1'b0;
    wait_rsp();
    chk("en_drop_rdata", last_rdata, 32'h55AA_33CC);
    chk("en_drop_stb",   last_stb,   4);
    tick();
    en_i = 1'b1;
    tick();

    // Asynchronous reset mid-transfer.
    do_req(32'h0000_5000, 32'h0, 1'b0, 0);
    repeat (2) tick();
    #1;
    rst_ni = 1'b0;
    #1;
    chk("arst_stb",       wb_stb_o,    1'b0);
    chk("arst_cyc",       wb_cyc_o,    1'b0);
    chk("arst_rsp_valid", rsp_valid_o, 1'b0);
    chk("arst_err_count", err_count_o, 8'd0);
    stb_run = 0;
    tick();
    rst_ni = 1'b1;
    start = rsp_cnt;
    repeat (20) tick();
    chk("arst_no_rsp", rsp_cnt - start, 0);
    chk("arst_ready",  req_ready_o,     1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_master_port.md
Name: wb_master_port

Overview:
- Wishbone initiator (master) used by core-side agents (e.g. a load/store unit or debug loader) to reach IRAM/DRAM through the Wishbone RAM slave.
- Accepts single-beat read/write requests on a valid/ready request port and runs one classic Wishbone cycle per request.
- Returns read data or a timeout error as a one-cycle response pulse.
- Guarantees at least one cycle with stb/cyc low between transfers, so the slave returns to its idle state before the next request.

Parameters:
- ADDR_WIDTH, 32, width of req_addr_i and wb_addr_o.
- DATA_WIDTH, 32, width of read and write data.
- TIMEOUT_CYCLES, 16, maximum number of cycles stb is held waiting for ack; 0 disables the timeout.

Ports:
- wb_clk_i  in  1  clock; all logic is in this domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  enable; gates acceptance of new requests only.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid and ready are both high at a rising edge.
- req_addr_i  in  ADDR_WIDTH  request byte address.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_we_i  in  1  1 = write, 0 = read.
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata_o  out  DATA_WIDTH  read data; valid with rsp_valid_o.
- rsp_err_o  out  1  timeout flag; valid with rsp_valid_o.
- wb_addr_o  out  ADDR_WIDTH  Wishbone address.
- wb_wdata_o  out  DATA_WIDTH  Wishbone write data.
- wb_we_o  out  1  Wishbone write enable.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_rdata_i  in  DATA_WIDTH  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- err_count_o  out  8  saturating count of timeouts since reset.

Behaviour:
- Reset: state IDLE; all outputs 0, including all data/address registers and err_count_o. The async reset aborts any in-flight cycle immediately: stb/cyc drop with no response.
- req_ready_o = (state == IDLE) & en_i. This is combinational from registered state.
- States:
  - IDLE -> BUS: on req_valid_i & req_ready_o.
    - Latch addr, wdata and we into the wb_* registers.
    - Set stb/cyc to 1 and clear the timeout counter.
  - BUS -> RESP: on wb_ack_i = 1 at an edge.
    - Clear stb, cyc and we.
    - Set rsp_valid_o=1 and rsp_err_o=0.
    - rsp_rdata_o = wb_rdata_i for reads; rsp_rdata_o = 0 for writes.
  - BUS -> RESP: on timeout (TIMEOUT_CYCLES ≠ 0, counter == TIMEOUT_CYCLES-1, no ack).
    - Clear stb, cyc and we.
    - Set rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0.
    - Increment err_count_o, saturating at 255.
  - BUS otherwise: hold all wb_* outputs stable and increment the counter.
  - RESP -> IDLE: unconditionally.
    - Clear rsp_valid_o.
    - rsp_rdata_o and rsp_err_o hold their values until the next response.
- Latency and timing:
  - Accept edge -> stb high in the next cycle.
  - Ack edge -> rsp_valid_o high in the next cycle.
  - Maximum throughput is 1 request per 3 cycles when the slave acks in the first stb cycle.
- Timeout: stb is held exactly TIMEOUT_CYCLES cycles before abort. The counter width is $clog2(TIMEOUT_CYCLES+1), with a minimum of 1.
- Simultaneous ack and timeout condition: ack wins, rsp_err_o=0 and no error count.
- wb_ack_i outside BUS is ignored; a late ack after a timeout has no effect.
- wb_rdata_i is sampled only on the ack edge.
- en_i deasserted during BUS or RESP: the in-flight transfer completes normally. en_i low only blocks the next acceptance.
- Request inputs are ignored after acceptance; the requester may change them freely.

Test Plan:
- Read: the slave acks 2 cycles after stb with wb_rdata_i=32'hDEADBEEF for req_addr_i=32'h0000_2004.
  - wb_addr_o=32'h0000_2004 and wb_we_o=0 during BUS; stb high for 2 cycles.
  - rsp_valid_o pulses 1 cycle with rsp_rdata_o=32'hDEADBEEF and rsp_err_o=0.
- Write: req_we_i=1, req_wdata_i=32'h12345678, immediate ack.
  - wb_we_o=1 and wb_wdata_o=32'h12345678 while stb is high.
  - Response has rsp_rdata_o=0 and err=0.
- Back-to-back: req_valid_i held high for 3 requests with immediate acks.
  - Accepts occur every 3rd cycle.
  - stb is low for at least 1 cycle between transfers; 3 responses are returned in order.
- Timeout: TIMEOUT_CYCLES=16 and wb_ack_i never asserted.
  - stb is high exactly 16 cycles, then rsp_err_o=1 and err_count_o=1.
  - An ack injected 2 cycles later is ignored.
- Ack on the final timeout cycle (cycle 16): rsp_err_o=0 and err_count_o is unchanged.
- Control corner cases:
  - en_i low during IDLE with req_valid_i=1: req_ready_o=0 and no stb.
  - en_i dropped mid-BUS: the transfer completes.
  - rst_ni pulsed mid-BUS: stb, cyc and rsp_valid_o are 0 immediately; no response is produced after reset release.
